// File: rtl/vector_pkg.sv
//------------------------------------------------------------------------------
// Module : vector_pkg
// Brief  : Shared pixel type and signed-max helper for the vector datapath.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vector_pkg;

  localparam int c_PIXEL_WIDTH = 16;

  typedef logic signed [c_PIXEL_WIDTH-1:0] pixel_t;

  function automatic pixel_t smax(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vector_linebuf.sv
//------------------------------------------------------------------------------
// Module : vector_linebuf
// Brief  : One-write/one-read synchronous RAM with registered read data.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vector_linebuf #(
  parameter int DEPTH      = 112,
  parameter int DATA_WIDTH = 16,
  localparam int c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [c_AW-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [c_AW-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage is left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/vector_maxpool.sv
//------------------------------------------------------------------------------
// Module : vector_maxpool
// Brief  : Streaming 2x2/stride-2 signed max-pool with half-width line buffer.
//          Optional ReLU clamp on the pooled result: VECTOR_MAXPOOL_RELU_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vector_maxpool
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  input  logic                  clear
);

  localparam int c_COL_W    = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int c_ROW_W    = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
  localparam int c_LB_DEPTH = IMG_WIDTH / 2;

  if (IMG_WIDTH % 2 != 0) begin : g_bad_width
    $error("vector_maxpool: IMG_WIDTH must be even");
  end
  if (IMG_HEIGHT % 2 != 0) begin : g_bad_height
    $error("vector_maxpool: IMG_HEIGHT must be even");
  end
  if (DATA_WIDTH != c_PIXEL_WIDTH) begin : g_bad_data_width
    $error("vector_maxpool: DATA_WIDTH must match vector_pkg pixel width");
  end

  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  pixel_t             r_hold;
  pixel_t             r_out_data;
  logic               r_out_valid;
  logic               r_out_last;

  pixel_t w_pix;
  pixel_t w_lb_rd_data;
  pixel_t w_pair_max;
  pixel_t w_win_max;
  pixel_t w_result;
  logic   w_in_fire;
  logic   w_out_fire;
  logic   w_col_last;
  logic   w_row_last;
  logic   w_lb_wr;
  logic   w_lb_rd;
  logic   w_load;

  assign w_pix      = pixel_t'(in_data);
  assign in_ready   = !clear && (!r_out_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_col_last = (r_col == c_COL_W'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == c_ROW_W'(IMG_HEIGHT - 1));

  // Odd-row reads are issued on the even column so data is ready for the odd one.
  assign w_lb_wr = w_in_fire && !r_row[0] &&  r_col[0];
  assign w_lb_rd = w_in_fire &&  r_row[0] && !r_col[0];
  assign w_load  = w_in_fire &&  r_row[0] &&  r_col[0];

  assign w_pair_max = smax(r_hold, w_pix);
  assign w_win_max  = smax(w_lb_rd_data, w_pair_max);

  always_comb begin
    w_result = w_win_max;
`ifdef VECTOR_MAXPOOL_RELU_EN
    if (w_win_max[c_PIXEL_WIDTH-1]) begin
      w_result = '0;
    end
`endif
  end

  vector_linebuf #(
    .DEPTH      (c_LB_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_linebuf (
    .clk     (clk),
    .wr_en   (w_lb_wr),
    .wr_addr (r_col[c_COL_W-1:1]),
    .wr_data (w_pair_max),
    .rd_en   (w_lb_rd),
    .rd_addr (r_col[c_COL_W-1:1]),
    .rd_data (w_lb_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (clear) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_in_fire) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + c_ROW_W'(1);
        end else begin
          r_col <= r_col + c_COL_W'(1);
        end
        if (!r_col[0]) begin
          r_hold <= w_pix;
        end
      end
      // A new result wins over the transfer of the previous one.
      if (w_load) begin
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
        r_out_last  <= w_row_last && w_col_last;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

`default_nettype wire
